// File: rtl/cgra_stream_pkg.sv
// Shared types and constants for the FIFO-to-AXI-Stream drain path.
package cgra_stream_pkg;

  localparam int unsigned SKID_DEPTH = 3;
  localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int unsigned PTR_W      = $clog2(SKID_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } drain_state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Small circular buffer absorbing the FIFO read latency in front of the stream port.
module axis_skid_buf
  import cgra_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [OCC_W-1:0]      occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_i) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    // Simultaneous write and read leaves the count unchanged.
    occ_d = occ_q + OCC_W'(wr_i) - OCC_W'(rd_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_i && !rd_i && (occ_q == OCC_W'(SKID_DEPTH))));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_i && (occ_q == '0)));

endmodule

// File: rtl/fifo_axis_drain.sv
// Drains an upstream synchronous FIFO (1-cycle read latency) into an AXI-Stream master,
// framing packets of PKT_LEN beats with tlast.
module fifo_axis_drain
  import cgra_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam int unsigned PEND_W    = OCC_W + 1;
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  drain_state_e     state_q, state_d;
  logic             inflight_q;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic [OCC_W-1:0] occ;
  logic [PEND_W-1:0] pending;
  logic             handshake;

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_i      (inflight_q),
    .wr_data_i (fifo_dout),
    .rd_i      (handshake),
    .head_o    (m_axis_tdata),
    .occ_o     (occ)
  );

  // Pop only when the buffer can absorb every outstanding read; tready is deliberately
  // not a term here so the pop strobe stays off the downstream timing path.
  assign pending   = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
  assign fifo_pop  = (state_q == StRun) && !fifo_empty && (pending < PEND_W'(SKID_DEPTH));

  assign m_axis_tvalid = (occ != '0);
  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt_q == LAST_BEAT);
  assign busy          = (state_q != StIdle);
  assign pkt_count     = pkt_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (!inflight_q && (occ == '0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The beat counter survives FSM transitions so a packet may span enable toggles.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;
    if (handshake) begin
      if (m_axis_tlast) begin
        beat_cnt_d  = '0;
        pkt_count_d = pkt_count_q + 16'd1;
      end else begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      inflight_q  <= 1'b0;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= fifo_pop;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Bench for fifo_axis_drain: directed table, corner sequences and a randomized run,
// all checked against an upstream FIFO model and an in-order beat scoreboard.
module tb_fifo_axis_drain;

  localparam int unsigned DW = 32;
  localparam int PL = 16;

  logic          clk = 1'b0;
  logic          rst_n, enable, tready;
  logic          fifo_empty, fifo_pop;
  logic [DW-1:0] fifo_dout = '0;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, busy;
  logic [15:0]   pkt_count;

  // Second instance with single-beat packets and its own trivial source.
  logic          en1, rdy1, empty1, pop1, valid1, last1, busy1;
  logic [DW-1:0] dout1 = '0;
  logic [DW-1:0] data1;
  logic [15:0]   pc1;
  int            ld1 = 0;
  int            pp1 = 0;

  always #5 clk = ~clk;

  // Upstream FIFO model: fmem[rd_idx..wr_idx-1] are the stored entries.
  logic [DW-1:0] fmem [0:4095];
  int wr_idx = 0;
  int rd_idx = 0;
  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (fifo_pop) begin
      fifo_dout <= fmem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end else begin
      fifo_dout <= '0;
    end
  end

  assign empty1 = (ld1 == pp1);
  always @(posedge clk) begin
    if (pop1) begin
      dout1 <= 32'hC0 + DW'(pp1);
      pp1   <= pp1 + 1;
    end else begin
      dout1 <= '0;
    end
  end

  fifo_axis_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_pop      (fifo_pop),
    .fifo_dout     (fifo_dout),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  fifo_axis_drain #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (en1),
    .fifo_empty    (empty1),
    .fifo_pop      (pop1),
    .fifo_dout     (dout1),
    .m_axis_tdata  (data1),
    .m_axis_tvalid (valid1),
    .m_axis_tready (rdy1),
    .m_axis_tlast  (last1),
    .busy          (busy1),
    .pkt_count     (pc1)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard state: exp_idx is the next FIFO entry expected on the stream.
  int            exp_idx = 0;
  int            beats = 0;
  int            hs_cnt = 0;
  int            pop_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  typedef struct {
    logic en;
    logic rdy;
    int   ncyc;
    logic exp_busy;
    logic exp_valid;
    logic exp_pop;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    if (!rst_n) begin
      exp_idx    = rd_idx;
      beats      = 0;
      prev_stall = 1'b0;
      return;
    end
    chk("pkt_count", 32'(pkt_count), 32'(16'(beats / PL)));
    chk("outstanding_le3", 32'(rd_idx - exp_idx <= 3), 32'd1);
    if (prev_stall) begin
      chk("stall_tvalid", 32'(tvalid), 32'd1);
      chk("stall_tdata", tdata, prev_data);
      chk("stall_tlast", 32'(tlast), 32'(prev_last));
    end
    if (fifo_pop) pop_cnt++;
    if (tvalid && tready) begin
      if (exp_idx < rd_idx) begin
        chk("beat_data", tdata, fmem[exp_idx]);
      end else begin
        chk("phantom_beat", 32'(exp_idx), 32'(rd_idx - 1));
      end
      chk("beat_tlast", 32'(tlast), 32'((beats % PL) == PL - 1));
      exp_idx++;
      beats++;
      hs_cnt++;
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
  endtask

  // Inputs change and directed checks happen at posedge+1; the scoreboard samples at negedge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_idx] = 32'h1000_0000 + DW'(wr_idx);
      wr_idx++;
    end
  endtask

  task automatic wait_valid(input string name, input int limit, output int n);
    n = 0;
    while (!tvalid && n < limit) begin
      tick();
      n++;
    end
    chk(name, 32'(tvalid), 32'd1);
  endtask

  initial begin
    int n, p0, h0, tv_fall, busy_fall;
    logic [DW-1:0] held, next_val;

    vecs[0] = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; enable = 1'b0; tready = 1'b0; en1 = 1'b0; rdy1 = 1'b0;
    #1;
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_tlast_pkt1", 32'(last1), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Empty FIFO: FSM walks its states, nothing is ever popped or presented.
    foreach (vecs[i]) begin
      enable = vecs[i].en;
      tready = vecs[i].rdy;
      repeat (vecs[i].ncyc) tick();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pop", i), 32'(fifo_pop), 32'(vecs[i].exp_pop));
    end

    // Basic drain of 0x1..0x10 at full rate.
    for (int i = 1; i <= 16; i++) begin
      fmem[wr_idx] = DW'(i);
      wr_idx++;
    end
    enable = 1'b1; tready = 1'b1;
    wait_valid("drain_first_valid", 10, n);
    chk("drain_latency", 32'(n), 32'd3);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_tvalid", 32'(tvalid), 32'd1);
      chk("drain_tdata", tdata, DW'(i));
      chk("drain_tlast", 32'(tlast), 32'(i == 16));
      tick();
    end
    chk("drain_pkt_count", 32'(pkt_count), 32'd1);
    chk("drain_done_tvalid", 32'(tvalid), 32'd0);

    // Backpressure: ten stalled cycles mid-stream.
    load(20);
    wait_valid("bp_first_valid", 10, n);
    repeat (4) tick();
    tready = 1'b0;
    held = tdata;
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_tvalid", 32'(tvalid), 32'd1);
      chk("bp_tdata_held", tdata, held);
    end
    chk("bp_pops_le3", 32'(pop_cnt - p0 <= 3), 32'd1);
    chk("bp_buffer_full", 32'(rd_idx - exp_idx), 32'd3);
    tready = 1'b1;
    n = 0;
    while ((exp_idx != wr_idx || tvalid) && n < 60) begin
      tick();
      n++;
    end
    chk("bp_all_delivered", 32'(exp_idx), 32'(wr_idx));
    enable = 1'b0;
    repeat (3) tick();
    chk("bp_idle", 32'(busy), 32'd0);

    // Enable drop with two buffered beats and one read in flight.
    load(10);
    enable = 1'b1; tready = 1'b0;
    repeat (4) tick();
    chk("ed_outstanding", 32'(rd_idx - exp_idx), 32'd3);
    chk("ed_tvalid", 32'(tvalid), 32'd1);
    enable = 1'b0; tready = 1'b1;
    p0 = pop_cnt; h0 = hs_cnt; tv_fall = -1; busy_fall = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!tvalid && tv_fall < 0) tv_fall = i;
      if (!busy && busy_fall < 0) busy_fall = i;
    end
    chk("ed_beats", 32'(hs_cnt - h0), 32'd3);
    chk("ed_pops", 32'(pop_cnt - p0), 32'd0);
    chk("ed_busy_lag", 32'(busy_fall - tv_fall), 32'd1);
    chk("ed_busy_fall", 32'(busy_fall), 32'd4);

    // Reset mid-stream with two buffered beats and one read in flight.
    enable = 1'b1; tready = 1'b0;
    repeat (4) tick();
    chk("rs_outstanding", 32'(rd_idx - exp_idx), 32'd3);
    next_val = fmem[rd_idx];
    rst_n = 1'b0;
    #1;
    chk("rs_tvalid", 32'(tvalid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_pop", 32'(fifo_pop), 32'd0);
    chk("rs_pkt_count", 32'(pkt_count), 32'd0);
    enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rs_quiet_tvalid", 32'(tvalid), 32'd0);
    chk("rs_quiet_busy", 32'(busy), 32'd0);
    chk("rs_quiet_pop", 32'(fifo_pop), 32'd0);
    enable = 1'b1; tready = 1'b1;
    wait_valid("rs_first_valid", 10, n);
    chk("rs_first_beat", tdata, next_val);
    chk("rs_first_tlast", 32'(tlast), 32'd0);

    // Randomized traffic, enable and backpressure.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 1 && wr_idx < 4000) load(1);
      enable = ($urandom_range(0, 9) != 0);
      tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    enable = 1'b1; tready = 1'b1;
    n = 0;
    while (exp_idx != wr_idx && n < 300) begin
      tick();
      n++;
    end
    chk("rnd_all_delivered", 32'(exp_idx), 32'(wr_idx));
    enable = 1'b0;
    repeat (4) tick();
    chk("rnd_idle", 32'(busy), 32'd0);
    chk("rnd_tvalid", 32'(tvalid), 32'd0);

    // Single-beat packets: every beat is last.
    ld1 = 4; en1 = 1'b1; rdy1 = 1'b1;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      if (valid1) begin
        chk("pkt1_tlast", 32'(last1), 32'd1);
        chk("pkt1_tdata", data1, 32'hC0 + DW'(n));
        n++;
      end
      tick();
    end
    chk("pkt1_beats", 32'(n), 32'd4);
    chk("pkt1_pkt_count", 32'(pc1), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
